// File: rtl/cbist_pkg.sv
// Shared definitions for the circular-BIST controller: FSM encoding, signature
// defaults and counter sizing.
package cbist_pkg;

  localparam int          CBIST_SIG_WIDTH  = 16;
  localparam logic [15:0] CBIST_GOLDEN_SIG = 16'hA5C3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Counter must hold the larger phase length minus one.
  function automatic int cnt_width(input int init_cycles, input int test_cycles);
    int m;
    m = (init_cycles > test_cycles) ? init_cycles : test_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cbist_cycle_counter.sv
// Phase cycle counter: clears on state entry, counts while enabled, flags the
// terminal count supplied by the controller.
module cbist_cycle_counter #(
  parameter int CW = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] terminal,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == terminal);

endmodule

// File: rtl/cbist_controller.sv
// Circular-BIST run controller: sequences seed, free-run and capture of the
// circular register and compares the captured signature to a golden value.
module cbist_controller
  import cbist_pkg::*;
#(
  parameter int                   SIG_WIDTH   = CBIST_SIG_WIDTH,
  parameter int                   INIT_CYCLES = 2,
  parameter int                   TEST_CYCLES = 256,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG  = SIG_WIDTH'(CBIST_GOLDEN_SIG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bist_start,
  input  logic                 bist_abort,
  input  logic [SIG_WIDTH-1:0] signature_in,
  output logic                 bist_mode,
  output logic                 sr_init,
  output logic                 sr_enable,
  output logic                 busy,
  output logic [SIG_WIDTH-1:0] signature_out,
  output logic                 bist_end,
  output logic                 pass_fail
);

  localparam int            CW      = cnt_width(INIT_CYCLES, TEST_CYCLES);
  localparam logic [CW-1:0] INIT_TC = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] TEST_TC = CW'(TEST_CYCLES - 1);

  logic [2:0]    state, state_nxt;
  logic          start_q, start_edge;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_term;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= bist_start;
  end

  assign start_edge = bist_start & ~start_q;

  // Abort outranks everything; a start edge is only honoured from IDLE/DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_edge && !bist_abort) state_nxt = ST_INIT;
      ST_INIT:    if (bist_abort) state_nxt = ST_IDLE;
                  else if (cnt_tc) state_nxt = ST_RUN;
      ST_RUN:     if (bist_abort) state_nxt = ST_IDLE;
                  else if (cnt_tc) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (bist_abort) state_nxt = ST_IDLE;
                  else state_nxt = ST_DONE;
      ST_DONE:    if (bist_abort) state_nxt = ST_IDLE;
                  else if (start_edge) state_nxt = ST_INIT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign cnt_clr  = (state_nxt != state);
  assign cnt_en   = (state == ST_INIT) || (state == ST_RUN);
  assign cnt_term = (state == ST_RUN) ? TEST_TC : INIT_TC;

  cbist_cycle_counter #(.CW(CW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (cnt_term),
    .tc       (cnt_tc)
  );

  // pass_fail is only meaningful in DONE, so any exit from DONE drops it;
  // signature_out survives aborts and restarts until the next capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      signature_out <= '0;
      pass_fail     <= 1'b0;
    end else if (state == ST_CAPTURE && state_nxt == ST_DONE) begin
      signature_out <= signature_in;
      pass_fail     <= (signature_in == GOLDEN_SIG);
    end else if (state_nxt != ST_DONE) begin
      pass_fail     <= 1'b0;
    end
  end

  assign sr_init   = (state == ST_INIT);
  assign sr_enable = (state == ST_RUN);
  assign busy      = sr_init | sr_enable | (state == ST_CAPTURE);
  assign bist_mode = busy;
  assign bist_end  = (state == ST_DONE);

endmodule

// File: doc/cbist_controller.md
CBIST_CONTROLLER -- requirements
Module: cbist_controller

Interface
REQ-001 SHALL provide parameter SIG_WIDTH, default 16: width of the circular-register signature.
REQ-002 SHALL provide parameter INIT_CYCLES, default 2: cycles spent seeding/clearing the circular register (legal range >=1).
REQ-003 SHALL provide parameter TEST_CYCLES, default 256: free-running circular-BIST cycles (legal range >=1).
REQ-004 SHALL provide parameter GOLDEN_SIG, default 16'hA5C3: expected fault-free signature.
REQ-005 SHALL have port clock  in  1  single clock; all state on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port bist_start  in  1  level input; a rising edge requests a test run.
REQ-008 SHALL have port bist_abort  in  1  level input; cancels the run in progress.
REQ-009 SHALL have port signature_in  in  SIG_WIDTH  current circular-register contents.
REQ-010 SHALL have port bist_mode  out  1  1 = circular-register path drives the arbiter under test; 0 = functional requests.
REQ-011 SHALL have port sr_init  out  1  clear/seed the circular register.
REQ-012 SHALL have port sr_enable  out  1  circular-register shift enable.
REQ-013 SHALL have port busy  out  1  run in progress (INIT, RUN or CAPTURE).
REQ-014 SHALL have port signature_out  out  SIG_WIDTH  captured signature.
REQ-015 SHALL have port bist_end  out  1  run complete; result valid.
REQ-016 SHALL have port pass_fail  out  1  1 = signature_out equals GOLDEN_SIG; qualified by bist_end.

Function
REQ-017 SHALL register bist_start once; start_edge = bist_start AND NOT registered bist_start.
REQ-018 SHALL implement FSM states IDLE, INIT, RUN, CAPTURE, DONE.
REQ-019 Transitions SHALL be: IDLE/DONE -> INIT on start_edge; INIT -> RUN after INIT_CYCLES cycles; RUN -> CAPTURE after TEST_CYCLES cycles; CAPTURE -> DONE after 1 cycle; DONE holds until start_edge or abort.
REQ-020 Moore outputs SHALL be: bist_mode=1 in INIT/RUN/CAPTURE; sr_init=1 only in INIT; sr_enable=1 only in RUN; busy=1 in INIT/RUN/CAPTURE; bist_end=1 only in DONE.
REQ-021 On the CAPTURE->DONE edge, signature_out SHALL load signature_in and pass_fail SHALL load (signature_in == GOLDEN_SIG).
REQ-022 bist_end SHALL rise exactly INIT_CYCLES+TEST_CYCLES+1 rising edges after the edge that enters INIT.
REQ-023 The cycle counter SHALL reload to 0 on every state entry; its width SHALL be clog2(max(INIT_CYCLES,TEST_CYCLES)+1); terminal count = parameter-1.
REQ-024 start_edge during INIT/RUN/CAPTURE SHALL be ignored and not queued.
REQ-025 bist_abort in INIT/RUN/CAPTURE/DONE SHALL move the FSM to IDLE on the next edge; signature_out SHALL be unchanged; pass_fail SHALL clear to 0.
REQ-026 Simultaneous bist_abort and start_edge SHALL resolve as abort (-> IDLE).
REQ-027 Re-entry to INIT from DONE SHALL clear bist_end and pass_fail on that edge; signature_out SHALL hold until the next CAPTURE.

Reset
REQ-028 reset SHALL asynchronously force state IDLE, counter 0, start register 0, signature_out 0, pass_fail 0; all outputs therefore 0.
REQ-029 reset asserted mid-run SHALL take effect without a clock edge; the run SHALL NOT resume on release.

Structure
REQ-030 State enumeration, SIG_WIDTH default and GOLDEN_SIG default SHALL live in shared package cbist_pkg.
REQ-031 Counting SHALL be in one sub-module cbist_cycle_counter (clear, enable, terminal-count flag); everything else inline.

Verification (INIT_CYCLES=2, TEST_CYCLES=16, GOLDEN_SIG=16'hA5C3)
REQ-032 Reset held, random inputs -> all outputs 0; signature_out=16'h0000.
REQ-033 start_edge, signature_in=16'hA5C3 at CAPTURE -> sr_init for 2 cycles, sr_enable for 16 cycles, bist_end at edge 19, pass_fail=1, signature_out=16'hA5C3.
REQ-034 Same run with signature_in=16'hA5C2 -> bist_end=1, pass_fail=0, signature_out=16'hA5C2.
REQ-035 bist_abort on RUN cycle 5 -> IDLE next edge, sr_enable=0, bist_end stays 0, signature_out keeps prior value.
REQ-036 bist_start held high through DONE -> no restart; drop, re-raise -> INIT, bist_end and pass_fail clear on that edge.
REQ-037 Async reset pulse mid-RUN between clock edges -> outputs 0 immediately; FSM IDLE after release.
